// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter sharing a single slave.
// m0 is the instruction port and m1 is the data port. A grant is held for as
// long as the granted master keeps cyc high. At least one IDLE cycle always
// separates two grants. Ties are resolved round-robin (RR_EN=1) or in favour
// of m1 (RR_EN=0).
module wb_arbiter2 #(
    parameter int RR_EN = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // master 0 (instruction port)
    input  logic [31:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    input  logic        m0_wb_we_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    output logic [31:0] m0_wb_dat_o,
    output logic        m0_wb_ack_o,
    // master 1 (data port)
    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    input  logic        m1_wb_we_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    output logic [31:0] m1_wb_dat_o,
    output logic        m1_wb_ack_o,
    // shared slave
    output logic [31:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    output logic        s_wb_we_o,
    output logic [3:0]  s_wb_sel_o,
    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    input  logic [31:0] s_wb_dat_i,
    input  logic        s_wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;
    // 0 = m0 was served most recently, 1 = m1 was
    logic   last_grant_reg;

    logic m0_req;
    logic m1_req;

    assign m0_req = m0_wb_cyc_i & m0_wb_stb_i;
    assign m1_req = m1_wb_cyc_i & m1_wb_stb_i;

    // State register and last-grant tracking; reset leaves m0 favoured on the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && state_next == GNT0) begin
                last_grant_reg <= 1'b0;
            end else if (state_reg == IDLE && state_next == GNT1) begin
                last_grant_reg <= 1'b1;
            end
        end
    end

    // Next-state logic: arbitrate only from IDLE, release when the owner drops cyc.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (m0_req && m1_req) begin
                    if (RR_EN != 0) begin
                        state_next = last_grant_reg ? GNT0 : GNT1;
                    end else begin
                        state_next = GNT1;
                    end
                end else if (m0_req) begin
                    state_next = GNT0;
                end else if (m1_req) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_wb_cyc_i) begin
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (!m1_wb_cyc_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output mux: the granted master drives the slave and alone sees its ack.
    always_comb begin
        s_wb_adr_o  = 32'd0;
        s_wb_dat_o  = 32'd0;
        s_wb_we_o   = 1'b0;
        s_wb_sel_o  = 4'd0;
        s_wb_cyc_o  = 1'b0;
        s_wb_stb_o  = 1'b0;
        m0_wb_ack_o = 1'b0;
        m1_wb_ack_o = 1'b0;
        case (state_reg)
            GNT0: begin
                s_wb_adr_o  = m0_wb_adr_i;
                s_wb_dat_o  = m0_wb_dat_i;
                s_wb_we_o   = m0_wb_we_i;
                s_wb_sel_o  = m0_wb_sel_i;
                s_wb_cyc_o  = m0_wb_cyc_i;
                s_wb_stb_o  = m0_wb_stb_i;
                m0_wb_ack_o = s_wb_ack_i;
            end
            GNT1: begin
                s_wb_adr_o  = m1_wb_adr_i;
                s_wb_dat_o  = m1_wb_dat_i;
                s_wb_we_o   = m1_wb_we_i;
                s_wb_sel_o  = m1_wb_sel_i;
                s_wb_cyc_o  = m1_wb_cyc_i;
                s_wb_stb_o  = m1_wb_stb_i;
                m1_wb_ack_o = s_wb_ack_i;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; only the ack tells a master the data is meant for it.
    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2. One instance runs round-robin (RR_EN=1) and
// a second runs fixed priority (RR_EN=0). Both instances share every input.
module tb_wb_arbiter2;

    logic        clk;
    logic        rst;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack_i;
    logic [3:0]  m0_sel, m1_sel;

    // round-robin instance outputs
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m1_ack_o, s_we_o, s_cyc_o, s_stb_o;
    logic [3:0]  s_sel_o;
    // fixed-priority instance outputs
    logic [31:0] fp_m0_dat_o, fp_m1_dat_o, fp_s_adr_o, fp_s_dat_o;
    logic        fp_m0_ack_o, fp_m1_ack_o, fp_s_we_o, fp_s_cyc_o, fp_s_stb_o;
    logic [3:0]  fp_s_sel_o;

    int vectors = 0;
    int errors  = 0;

    wb_arbiter2 #(.RR_EN(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_we_i(m0_we),
        .m0_wb_sel_i(m0_sel), .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb),
        .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack_o),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_we_i(m1_we),
        .m1_wb_sel_i(m1_sel), .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb),
        .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack_o),
        .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_we_o(s_we_o),
        .s_wb_sel_o(s_sel_o), .s_wb_cyc_o(s_cyc_o), .s_wb_stb_o(s_stb_o),
        .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack_i)
    );

    wb_arbiter2 #(.RR_EN(0)) dut_fp (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_we_i(m0_we),
        .m0_wb_sel_i(m0_sel), .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb),
        .m0_wb_dat_o(fp_m0_dat_o), .m0_wb_ack_o(fp_m0_ack_o),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_we_i(m1_we),
        .m1_wb_sel_i(m1_sel), .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb),
        .m1_wb_dat_o(fp_m1_dat_o), .m1_wb_ack_o(fp_m1_ack_o),
        .s_wb_adr_o(fp_s_adr_o), .s_wb_dat_o(fp_s_dat_o), .s_wb_we_o(fp_s_we_o),
        .s_wb_sel_o(fp_s_sel_o), .s_wb_cyc_o(fp_s_cyc_o), .s_wb_stb_o(fp_s_stb_o),
        .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then examined 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr = 32'd0; m0_dat = 32'd0; m0_we = 1'b0; m0_sel = 4'd0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = 32'd0; m1_dat = 32'd0; m1_we = 1'b0; m1_sel = 4'd0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_dat_i = 32'd0; s_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF;
        s_ack_i = 1'b1;
        step();
        step();
        vectors++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", s_cyc_o); end
        vectors++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", s_stb_o); end
        vectors++; if (s_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", s_we_o); end
        vectors++; if (s_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", s_sel_o); end
        vectors++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", {m0_ack_o, m1_ack_o}); end
        vectors++; if ({fp_s_cyc_o, fp_m0_ack_o, fp_m1_ack_o} !== 3'b000) begin errors++; $display("FAIL reset_fp: got %b want 000", {fp_s_cyc_o, fp_m0_ack_o, fp_m1_ack_o}); end
        rst = 1'b0;
        clear_inputs();
        $display("test_reset: done");
    endtask

    // m0 alone reads 0x100 and receives a single-cycle ack.
    task automatic test_solo_read();
        do_reset();
        m0_adr = 32'h0000_0100; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        #1;
        vectors++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL solo_latency: got cyc %b want 0", s_cyc_o); end
        step();
        vectors++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin errors++; $display("FAIL solo_cyc: got %b%b want 11", s_cyc_o, s_stb_o); end
        vectors++; if (s_adr_o !== 32'h0000_0100) begin errors++; $display("FAIL solo_adr: got %h want 00000100", s_adr_o); end
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        vectors++; if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL solo_m0_ack: got %b want 1", m0_ack_o); end
        vectors++; if (m0_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL solo_m0_dat: got %h want deadbeef", m0_dat_o); end
        vectors++; if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL solo_m1_ack: got %b want 0", m1_ack_o); end
        vectors++; if (m1_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL solo_m1_dat: got %h want deadbeef", m1_dat_o); end
        step();
        s_ack_i = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
        s_ack_i = 1'b1;
        #1;
        vectors++; if ({s_cyc_o, m0_ack_o} !== 2'b00) begin errors++; $display("FAIL solo_release: got %b want 00", {s_cyc_o, m0_ack_o}); end
        clear_inputs();
        $display("test_solo_read: done");
    endtask

    // Round-robin tie after reset: m0 first, an IDLE gap, then m1, then m0 again.
    task automatic test_tie_rr();
        do_reset();
        m0_adr = 32'h0000_0200; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'h0000_0300; m1_dat = 32'h1234_5678; m1_we = 1'b1; m1_sel = 4'b0011;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        vectors++; if (s_adr_o !== 32'h0000_0200) begin errors++; $display("FAIL rr_first_adr: got %h want 00000200", s_adr_o); end
        s_ack_i = 1'b1;
        #1;
        vectors++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin errors++; $display("FAIL rr_first_ack: got %b want 10", {m0_ack_o, m1_ack_o}); end
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack_i = 1'b0;
        step();
        s_ack_i = 1'b1;
        #1;
        vectors++; if ({s_cyc_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL rr_idle_gap: got %b want 00", {s_cyc_o, m1_ack_o}); end
        s_ack_i = 1'b0;
        step();
        vectors++; if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_0300) begin errors++; $display("FAIL rr_second_adr: got cyc %b adr %h want 1 00000300", s_cyc_o, s_adr_o); end
        vectors++; if (s_we_o !== 1'b1 || s_sel_o !== 4'b0011) begin errors++; $display("FAIL rr_second_we_sel: got %b %b want 1 0011", s_we_o, s_sel_o); end
        vectors++; if (s_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL rr_second_dat: got %h want 12345678", s_dat_o); end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        vectors++; if (s_adr_o !== 32'h0000_0200) begin errors++; $display("FAIL rr_alternate: got %h want 00000200", s_adr_o); end
        clear_inputs();
        $display("test_tie_rr: done");
    endtask

    // Fixed priority: m1 wins every tie and m0 never sees an ack meanwhile.
    task automatic test_fixed_priority();
        do_reset();
        m0_adr = 32'h0000_0200; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'h0000_0300; m1_we = 1'b1; m1_sel = 4'b0011; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        vectors++; if (fp_s_adr_o !== 32'h0000_0300 || fp_s_we_o !== 1'b1) begin errors++; $display("FAIL fp_first: got adr %h we %b want 00000300 1", fp_s_adr_o, fp_s_we_o); end
        for (int i = 0; i < 2; i++) begin
            s_ack_i = 1'b1;
            #1;
            vectors++; if ({fp_m0_ack_o, fp_m1_ack_o} !== 2'b01) begin errors++; $display("FAIL fp_beat%0d_ack: got %b want 01", i, {fp_m0_ack_o, fp_m1_ack_o}); end
            step();
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; s_ack_i = 1'b0;
        step();
        vectors++; if (fp_s_cyc_o !== 1'b0) begin errors++; $display("FAIL fp_idle: got %b want 0", fp_s_cyc_o); end
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        s_ack_i = 1'b1;
        #1;
        vectors++; if (fp_s_adr_o !== 32'h0000_0300 || fp_m0_ack_o !== 1'b0) begin errors++; $display("FAIL fp_second: got adr %h m0_ack %b want 00000300 0", fp_s_adr_o, fp_m0_ack_o); end
        clear_inputs();
        $display("test_fixed_priority: done");
    endtask

    // m1 aborts before ack; a late ack in IDLE must reach nobody.
    task automatic test_abort();
        do_reset();
        m1_adr = 32'h0000_0400; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        vectors++; if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_0400) begin errors++; $display("FAIL abort_grant: got cyc %b adr %h want 1 00000400", s_cyc_o, s_adr_o); end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        s_ack_i = 1'b1;
        #1;
        vectors++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL abort_late_ack: got %b want 00", {m0_ack_o, m1_ack_o}); end
        m1_cyc = 1'b1;
        #1;
        vectors++; if ({s_cyc_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b want 00", {s_cyc_o, m1_ack_o}); end
        clear_inputs();
        $display("test_abort: done");
    endtask

    // Reset during an m0 grant drops the bus and restores m0 tie priority.
    task automatic test_reset_mid();
        do_reset();
        m0_adr = 32'h0000_0500; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        vectors++; if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL rmid_grant: got %b want 1", s_cyc_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rmid_cyc: got %b want 0", s_cyc_o); end
        s_ack_i = 1'b1;
        #1;
        vectors++; if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL rmid_ack: got %b want 0", m0_ack_o); end
        s_ack_i = 1'b0;
        m1_adr = 32'h0000_0600; m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        vectors++; if (s_adr_o !== 32'h0000_0500) begin errors++; $display("FAIL rmid_tie: got %h want 00000500", s_adr_o); end
        clear_inputs();
        $display("test_reset_mid: done");
    endtask

    // m0 keeps the bus for three acked beats while m1 waits.
    task automatic test_back_to_back();
        do_reset();
        m0_adr = 32'h0000_1000; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        m1_adr = 32'h0000_2000; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m0_adr = 32'h0000_1000 + 32'(i * 4);
            s_ack_i = 1'b1;
            #1;
            vectors++; if (s_adr_o !== 32'h0000_1000 + 32'(i * 4)) begin errors++; $display("FAIL b2b_beat%0d_adr: got %h want %h", i, s_adr_o, 32'h0000_1000 + 32'(i * 4)); end
            vectors++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin errors++; $display("FAIL b2b_beat%0d_ack: got %b want 10", i, {m0_ack_o, m1_ack_o}); end
            step();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack_i = 1'b0;
        step();
        vectors++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", s_cyc_o); end
        step();
        s_ack_i = 1'b1;
        #1;
        vectors++; if (s_adr_o !== 32'h0000_2000 || m1_ack_o !== 1'b1) begin errors++; $display("FAIL b2b_m1: got adr %h ack %b want 00002000 1", s_adr_o, m1_ack_o); end
        clear_inputs();
        $display("test_back_to_back: done");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_solo_read();
        test_tie_rr();
        test_fixed_priority();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
